// File: rtl/ysyx_24110015_lsu_axi_if.sv
// Request/response and AXI-lite bus bundle for ysyx_24110015_lsu_axi.
// master = LSU view; slave = controller plus memory-side view.
interface ysyx_24110015_lsu_axi_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_func3;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic [1:0]            resp_err;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arsize;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awsize;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    input  req_valid, req_we, req_func3, req_addr, req_wdata,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output arvalid, araddr, arsize, rready, awvalid, awaddr, awsize, wvalid, wdata, wstrb, bready
  );

  modport slave (
    output req_valid, req_we, req_func3, req_addr, req_wdata,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  arvalid, araddr, arsize, rready, awvalid, awaddr, awsize, wvalid, wdata, wstrb, bready
  );
endinterface

// File: rtl/ysyx_24110015_lsu_axi.sv
// Load/store unit: one request at a time as a single-beat AXI-lite read or write.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned requests with err=1.
module ysyx_24110015_lsu_axi #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  ysyx_24110015_lsu_axi_if.master bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWr, StWrResp, StDone} state_e;

  state_e              r_state, w_state_d;
  logic                r_req_ready, w_req_ready_d;
  logic                r_arvalid, w_arvalid_d;
  logic                r_rready, w_rready_d;
  logic                r_awvalid, w_awvalid_d;
  logic                r_wvalid, w_wvalid_d;
  logic                r_bready, w_bready_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [2:0]          r_size, w_size_d;
  logic [2:0]          r_func3, w_func3_d;
  logic [OFF_W-1:0]    r_off, w_off_d;
  logic [DATA_W-1:0]   r_wdata, w_wdata_d;
  logic [STRB_W-1:0]   r_wstrb, w_wstrb_d;
  logic                r_resp_valid, w_resp_valid_d;
  logic [DATA_W-1:0]   r_resp_rdata, w_resp_rdata_d;
  logic [1:0]          r_resp_err, w_resp_err_d;

  logic [2:0]          w_f3;
  logic [OFF_W-1:0]    w_req_off;
  logic                w_accept, w_illegal, w_misalign, w_sign;
  logic [STRB_W-1:0]   w_mask;
  logic [DATA_W-1:0]   w_rshift, w_ext;
  int                  w_nbits;

  assign w_f3      = bus.req_func3;
  assign w_req_off = bus.req_addr[OFF_W-1:0];
  assign w_accept  = (r_state == StIdle) && r_req_ready && bus.req_valid;
  // ld/lwu/sd only exist on a 64-bit bus; stores have no unsigned variants.
  assign w_illegal = (w_f3 == 3'b111) || (bus.req_we && w_f3[2]) ||
                     ((DATA_W == 32) && ((w_f3 == 3'b011) || (w_f3 == 3'b110)));

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = ((w_f3[1:0] == 2'd1) && bus.req_addr[0]) ||
                      ((w_f3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'b00)) ||
                      ((w_f3[1:0] == 2'd3) && (bus.req_addr[2:0] != 3'b000));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    unique case (w_f3[1:0])
      2'd0:    w_mask = STRB_W'(8'h01);
      2'd1:    w_mask = STRB_W'(8'h03);
      2'd2:    w_mask = STRB_W'(8'h0F);
      default: w_mask = STRB_W'(8'hFF);
    endcase
  end

  assign w_rshift = bus.rdata >> {r_off, 3'b000};
  assign w_sign   = ~r_func3[2];

  always_comb begin
    unique case (r_func3[1:0])
      2'd0:    w_nbits = 8;
      2'd1:    w_nbits = 16;
      2'd2:    w_nbits = 32;
      default: w_nbits = DATA_W;
    endcase
    w_ext = w_rshift;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= w_nbits) w_ext[i] = w_sign & w_rshift[w_nbits-1];
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_arvalid_d    = r_arvalid;
    w_rready_d     = r_rready;
    w_awvalid_d    = r_awvalid;
    w_wvalid_d     = r_wvalid;
    w_bready_d     = r_bready;
    w_addr_d       = r_addr;
    w_size_d       = r_size;
    w_func3_d      = r_func3;
    w_off_d        = r_off;
    w_wdata_d      = r_wdata;
    w_wstrb_d      = r_wstrb;
    w_resp_rdata_d = r_resp_rdata;
    w_resp_err_d   = r_resp_err;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_addr_d  = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          w_size_d  = {1'b0, w_f3[1:0]};
          w_func3_d = w_f3;
          w_off_d   = w_req_off;
          w_wdata_d = bus.req_wdata << {w_req_off, 3'b000};
          w_wstrb_d = w_mask << w_req_off;
          if (w_illegal || w_misalign) begin
            w_state_d      = StDone;
            w_resp_err_d   = 2'd1;
            w_resp_rdata_d = '0;
          end else if (bus.req_we) begin
            w_state_d   = StWr;
            w_awvalid_d = 1'b1;
            w_wvalid_d  = 1'b1;
          end else begin
            w_state_d   = StRdAddr;
            w_arvalid_d = 1'b1;
          end
        end
      end
      StRdAddr: begin
        if (bus.arready) begin
          w_arvalid_d = 1'b0;
          w_rready_d  = 1'b1;
          w_state_d   = StRdData;
        end
      end
      StRdData: begin
        if (bus.rvalid) begin
          w_rready_d     = 1'b0;
          w_state_d      = StDone;
          w_resp_err_d   = (bus.rresp != 2'b00) ? 2'd2 : 2'd0;
          w_resp_rdata_d = (bus.rresp != 2'b00) ? '0 : w_ext;
        end
      end
      StWr: begin
        w_awvalid_d = r_awvalid & ~bus.awready;
        w_wvalid_d  = r_wvalid & ~bus.wready;
        if (!w_awvalid_d && !w_wvalid_d) begin
          w_bready_d = 1'b1;
          w_state_d  = StWrResp;
        end
      end
      StWrResp: begin
        if (bus.bvalid) begin
          w_bready_d     = 1'b0;
          w_state_d      = StDone;
          w_resp_err_d   = (bus.bresp != 2'b00) ? 2'd2 : 2'd0;
          w_resp_rdata_d = '0;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    w_resp_valid_d = (w_state_d == StDone);
    w_req_ready_d  = (w_state_d == StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_req_ready  <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_addr       <= '0;
      r_size       <= '0;
      r_func3      <= '0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_req_ready  <= w_req_ready_d;
      r_arvalid    <= w_arvalid_d;
      r_rready     <= w_rready_d;
      r_awvalid    <= w_awvalid_d;
      r_wvalid     <= w_wvalid_d;
      r_bready     <= w_bready_d;
      r_addr       <= w_addr_d;
      r_size       <= w_size_d;
      r_func3      <= w_func3_d;
      r_off        <= w_off_d;
      r_wdata      <= w_wdata_d;
      r_wstrb      <= w_wstrb_d;
      r_resp_valid <= w_resp_valid_d;
      r_resp_rdata <= w_resp_rdata_d;
      r_resp_err   <= w_resp_err_d;
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.arvalid    = r_arvalid;
  assign bus.araddr     = r_addr;
  assign bus.arsize     = r_size;
  assign bus.rready     = r_rready;
  assign bus.awvalid    = r_awvalid;
  assign bus.awaddr     = r_addr;
  assign bus.awsize     = r_size;
  assign bus.wvalid     = r_wvalid;
  assign bus.wdata      = r_wdata;
  assign bus.wstrb      = r_wstrb;
  assign bus.bready     = r_bready;
endmodule
